user_obi_rr_arb: RTL and testbench

USER_OBI_RR_ARB -- requirements
Module: user_obi_rr_arb

---
 rtl/user_pkg.sv | 31 +++
 rtl/fifo_v3.sv | 90 +++++++++
 rtl/user_obi_rr_arb.sv | 170 +++++++++++++++++
 tb/tb_user_obi_rr_arb.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_pkg.sv
// Shared constants and types for the user-subordinate OBI arbiter.
// Arbiter sizing, subordinate map index and the lock FSM encoding.
package user_pkg;

    // Number of OBI managers sharing the user subordinate.
    localparam int unsigned UserArbNumMgr   = 2;
    // Granted-but-unanswered transactions the arbiter can track.
    localparam int unsigned UserArbMaxTrans = 2;

    // Subordinate map: the arbiter fronts the user ROM.
    localparam int unsigned UserRom    = 0;
    localparam int unsigned UserRam    = 1;
    localparam int unsigned UserNumSbr = 2;

    typedef enum logic {
        ArbIdle   = 1'b0,
        ArbLocked = 1'b1
    } arb_state_e;

    // Round-robin successor of idx among n managers.
    function automatic int unsigned rr_next(
        input int unsigned idx,
        input int unsigned n
    );
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO compatible with the common_cells fifo_v3 core.
// Optional fall-through mode; flush empties the queue in one cycle.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    typedef logic [ADDR_DEPTH-1:0] ptr_t;
    typedef logic [ADDR_DEPTH:0]   cnt_t;

    localparam ptr_t LastPtr = ptr_t'(DEPTH - 1);
    localparam cnt_t FullCnt = cnt_t'(DEPTH);

    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t wr_ptr_q, wr_ptr_d;
    cnt_t cnt_q, cnt_d;
    dtype mem_q [DEPTH];
    dtype mem_d [DEPTH];

    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0) & ~(FALL_THROUGH & push_i);

    // Pointer, occupancy and storage next-state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        data_o   = mem_q[rd_ptr_q];

        if (push_i && !full_o) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + ptr_t'(1);
            cnt_d    = cnt_q + cnt_t'(1);
        end

        if (pop_i && !empty_o) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + ptr_t'(1);
            cnt_d    = cnt_q - cnt_t'(1);
        end

        if (push_i && pop_i && !full_o && !empty_o) begin
            cnt_d = cnt_q;
        end

        if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
            data_o = data_i;
            if (pop_i) begin
                cnt_d    = cnt_q;
                rd_ptr_d = rd_ptr_q;
                wr_ptr_d = wr_ptr_q;
            end
        end

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    // FIFO state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            mem_q    <= '{default: '0};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/user_obi_rr_arb.sv
// Round-robin OBI arbiter: NumMgr managers onto one user subordinate.
// In-order responses are steered back using a FIFO of granted indices.
module user_obi_rr_arb
    import user_pkg::*;
#(
    parameter int unsigned NumMgr   = UserArbNumMgr,
    parameter int unsigned MaxTrans = UserArbMaxTrans
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumMgr-1:0]       mgr_req_i,
    input  logic [NumMgr-1:0][31:0] mgr_addr_i,
    input  logic [NumMgr-1:0][31:0] mgr_wdata_i,
    input  logic [NumMgr-1:0]       mgr_we_i,
    input  logic [NumMgr-1:0][3:0]  mgr_be_i,
    output logic [NumMgr-1:0]       mgr_gnt_o,
    output logic [NumMgr-1:0]       mgr_rvalid_o,
    output logic [31:0]             mgr_rdata_o,
    output logic                   mgr_err_o,
    output logic                   sbr_req_o,
    output logic                   sbr_we_o,
    output logic [31:0]             sbr_addr_o,
    output logic [31:0]             sbr_wdata_o,
    output logic [3:0]              sbr_be_o,
    input  logic                   sbr_gnt_i,
    input  logic                   sbr_rvalid_i,
    input  logic                   sbr_err_i,
    input  logic [31:0]             sbr_rdata_i,
    output logic                   spurious_rsp_o
);

    localparam int unsigned IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
    typedef logic [IdxW-1:0] idx_t;

    arb_state_e state_q, state_d;
    idx_t       lock_idx_q, lock_idx_d;
    idx_t       rr_ptr_q, rr_ptr_d;

    idx_t        rr_sel;
    idx_t        sel;
    idx_t        sel_next;
    logic        found;
    int unsigned cand;
    logic        any_req;
    logic        hs;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    idx_t        fifo_head;
    logic        fifo_rst_n;

    assign any_req = |mgr_req_i;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        rr_sel = rr_ptr_q;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned k = 0; k < NumMgr; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= NumMgr) begin
                cand = cand - NumMgr;
            end
            if (!found && mgr_req_i[cand[IdxW-1:0]]) begin
                found  = 1'b1;
                rr_sel = cand[IdxW-1:0];
            end
        end
    end

    // A pending, ungranted request keeps its manager selected.
    assign sel = (state_q == ArbLocked) ? lock_idx_q : rr_sel;
    assign sel_next = idx_t'(rr_next(32'(sel), NumMgr));

    assign sbr_req_o = any_req & ~fifo_full;
    assign hs        = sbr_req_o & sbr_gnt_i;

    // Request fields follow the selected manager; idle bus reads zero.
    always_comb begin
        sbr_addr_o  = '0;
        sbr_wdata_o = '0;
        sbr_we_o    = 1'b0;
        sbr_be_o    = '0;
        if (any_req) begin
            sbr_addr_o  = mgr_addr_i[sel];
            sbr_wdata_o = mgr_wdata_i[sel];
            sbr_we_o    = mgr_we_i[sel];
            sbr_be_o    = mgr_be_i[sel];
        end
    end

    // Lock FSM and round-robin pointer next-state.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        unique case (state_q)
            ArbIdle: begin
                if (hs) begin
                    rr_ptr_d = sel_next;
                end else if (sbr_req_o) begin
                    state_d    = ArbLocked;
                    lock_idx_d = sel;
                end
            end
            ArbLocked: begin
                if (hs) begin
                    state_d  = ArbIdle;
                    rr_ptr_d = sel_next;
                end
            end
            default: begin
                state_d = ArbIdle;
            end
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ArbIdle;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // One-hot grant to the selected manager on handshake.
    always_comb begin
        mgr_gnt_o = '0;
        if (hs) begin
            mgr_gnt_o[sel] = 1'b1;
        end
    end

    assign fifo_pop       = sbr_rvalid_i & ~fifo_empty;
    assign spurious_rsp_o = sbr_rvalid_i & fifo_empty;
    assign mgr_rdata_o    = sbr_rdata_i;
    assign mgr_err_o      = sbr_err_i;

    // Route the response to the oldest outstanding manager.
    always_comb begin
        mgr_rvalid_o = '0;
        if (fifo_pop) begin
            mgr_rvalid_o[fifo_head] = 1'b1;
        end
    end

    assign fifo_rst_n = ~rst_i;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (IdxW),
        .DEPTH        (MaxTrans)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (fifo_rst_n),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_i  (sel),
        .push_i  (hs),
        .data_o  (fifo_head),
        .pop_i   (fifo_pop)
    );

endmodule

// File: tb/tb_user_obi_rr_arb.sv
// Self-checking bench for user_obi_rr_arb.
// Directed vector table, hand sequences, then random vs. queue model.
module tb_user_obi_rr_arb;

    localparam int N = 2;
    localparam int M = 2;
    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]       mgr_req;
    logic [N-1:0][31:0] mgr_addr;
    logic [N-1:0][31:0] mgr_wdata;
    logic [N-1:0]       mgr_we;
    logic [N-1:0][3:0]  mgr_be;
    logic [N-1:0]       mgr_gnt;
    logic [N-1:0]       mgr_rvalid;
    logic [31:0]        mgr_rdata;
    logic               mgr_err;
    logic               sbr_req;
    logic               sbr_we;
    logic [31:0]        sbr_addr;
    logic [31:0]        sbr_wdata;
    logic [3:0]         sbr_be;
    logic               sbr_gnt;
    logic               sbr_rvalid;
    logic               sbr_err;
    logic [31:0]        sbr_rdata;
    logic               spurious;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    user_obi_rr_arb #(
        .NumMgr   (N),
        .MaxTrans (M)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .mgr_req_i      (mgr_req),
        .mgr_addr_i     (mgr_addr),
        .mgr_wdata_i    (mgr_wdata),
        .mgr_we_i       (mgr_we),
        .mgr_be_i       (mgr_be),
        .mgr_gnt_o      (mgr_gnt),
        .mgr_rvalid_o   (mgr_rvalid),
        .mgr_rdata_o    (mgr_rdata),
        .mgr_err_o      (mgr_err),
        .sbr_req_o      (sbr_req),
        .sbr_we_o       (sbr_we),
        .sbr_addr_o     (sbr_addr),
        .sbr_wdata_o    (sbr_wdata),
        .sbr_be_o       (sbr_be),
        .sbr_gnt_i      (sbr_gnt),
        .sbr_rvalid_i   (sbr_rvalid),
        .sbr_err_i      (sbr_err),
        .sbr_rdata_i    (sbr_rdata),
        .spurious_rsp_o (spurious)
    );

    typedef struct {
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic        e_sreq;
        logic [1:0]  e_gnt;
        logic [1:0]  e_rv;
        logic        e_spur;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs [12];

    // Reference model: outstanding manager ids in grant order.
    int q [$];
    int ptr;
    bit locked;
    int lidx;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt,
                         input logic rv);
        mgr_req    = req;
        sbr_gnt    = gnt;
        sbr_rvalid = rv;
    endtask

    task automatic idle_inputs();
        drive(2'b00, 1'b0, 1'b0);
        sbr_rdata = '0;
        sbr_err   = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        ptr    = 0;
        locked = 0;
        lidx   = 0;
    endtask

    // Predict outputs from current inputs, compare, then advance model.
    task automatic model_check();
        int          sel;
        bit          any;
        bit          full;
        bit          ereq;
        bit          hs;
        bit          pop;
        logic [1:0]  egnt;
        logic [1:0]  erv;
        logic [31:0] eaddr;
        logic [31:0] ewdata;
        logic        ewe;
        logic [3:0]  ebe;
        any  = |mgr_req;
        full = (q.size() >= M);
        ereq = any && !full;
        sel  = 0;
        if (locked) begin
            sel = lidx;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (mgr_req[(ptr + k) % N]) begin
                    sel = (ptr + k) % N;
                    break;
                end
            end
        end
        hs   = ereq && sbr_gnt;
        pop  = sbr_rvalid && (q.size() > 0);
        egnt = hs ? 2'(1 << sel) : 2'b00;
        erv  = pop ? 2'(1 << q[0]) : 2'b00;
        eaddr  = any ? mgr_addr[sel] : 32'h0;
        ewdata = any ? mgr_wdata[sel] : 32'h0;
        ewe    = any ? mgr_we[sel] : 1'b0;
        ebe    = any ? mgr_be[sel] : 4'h0;
        chk("rnd_sbr_req", sbr_req, ereq);
        chk("rnd_gnt", mgr_gnt, egnt);
        chk("rnd_rvalid", mgr_rvalid, erv);
        chk("rnd_spurious", spurious, sbr_rvalid && (q.size() == 0));
        chk("rnd_addr", sbr_addr, eaddr);
        chk("rnd_wdata", sbr_wdata, ewdata);
        chk("rnd_we", sbr_we, ewe);
        chk("rnd_be", sbr_be, ebe);
        chk("rnd_rdata", mgr_rdata, sbr_rdata);
        chk("rnd_err", mgr_err, sbr_err);
        if (pop) void'(q.pop_front());
        if (hs) begin
            q.push_back(sel);
            ptr    = (sel + 1) % N;
            locked = 0;
        end else if (ereq) begin
            locked = 1;
            lidx   = sel;
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        mgr_addr[0] = A0;
        mgr_addr[1] = A1;
        mgr_wdata   = '0;
        mgr_we      = '0;
        mgr_be      = '0;

        vecs[0]  = '{2'b00, 1'b0, 1'b1, 32'h0, 1'b0,
                     1'b0, 2'b00, 2'b00, 1'b1, 32'h0};
        vecs[1]  = '{2'b11, 1'b1, 1'b0, 32'h0, 1'b0,
                     1'b1, 2'b01, 2'b00, 1'b0, A0};
        vecs[2]  = '{2'b11, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0,
                     1'b1, 2'b10, 2'b01, 1'b0, A1};
        vecs[3]  = '{2'b11, 1'b1, 1'b1, 32'h1234_5678, 1'b1,
                     1'b1, 2'b01, 2'b10, 1'b0, A0};
        vecs[4]  = '{2'b11, 1'b1, 1'b1, 32'h0, 1'b0,
                     1'b1, 2'b10, 2'b01, 1'b0, A1};
        vecs[5]  = '{2'b11, 1'b1, 1'b0, 32'h0, 1'b0,
                     1'b1, 2'b01, 2'b00, 1'b0, A0};
        vecs[6]  = '{2'b11, 1'b1, 1'b0, 32'h0, 1'b0,
                     1'b0, 2'b00, 2'b00, 1'b0, A1};
        vecs[7]  = '{2'b11, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0,
                     1'b0, 2'b00, 2'b10, 1'b0, A1};
        vecs[8]  = '{2'b11, 1'b1, 1'b0, 32'h0, 1'b0,
                     1'b1, 2'b10, 2'b00, 1'b0, A1};
        vecs[9]  = '{2'b00, 1'b0, 1'b1, 32'h0, 1'b0,
                     1'b0, 2'b00, 2'b01, 1'b0, 32'h0};
        vecs[10] = '{2'b00, 1'b0, 1'b1, 32'h0, 1'b0,
                     1'b0, 2'b00, 2'b10, 1'b0, 32'h0};
        vecs[11] = '{2'b00, 1'b0, 1'b1, 32'h0, 1'b0,
                     1'b0, 2'b00, 2'b00, 1'b1, 32'h0};

        // Reset state.
        tick();
        tick();
        chk("rst_sbr_req", sbr_req, 1'b0);
        chk("rst_gnt", mgr_gnt, 2'b00);
        chk("rst_rvalid", mgr_rvalid, 2'b00);
        chk("rst_spurious", spurious, 1'b0);
        chk("rst_addr", sbr_addr, 32'h0);
        rst = 1'b0;
        tick();

        // Directed table: alternation, full blocking, push+pop, spurious.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].req, vecs[i].gnt, vecs[i].rv);
            sbr_rdata = vecs[i].rdata;
            sbr_err   = vecs[i].err;
            #3;
            chk($sformatf("vec%0d_sbr_req", i), sbr_req, vecs[i].e_sreq);
            chk($sformatf("vec%0d_gnt", i), mgr_gnt, vecs[i].e_gnt);
            chk($sformatf("vec%0d_rvalid", i), mgr_rvalid, vecs[i].e_rv);
            chk($sformatf("vec%0d_spur", i), spurious, vecs[i].e_spur);
            chk($sformatf("vec%0d_addr", i), sbr_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_rdata", i), mgr_rdata, vecs[i].rdata);
            chk($sformatf("vec%0d_err", i), mgr_err, vecs[i].err);
            tick();
        end
        idle_inputs();

        // Lock: M1 waits three cycles, M0 joins but must not steal.
        drive(2'b10, 1'b0, 1'b0);
        #3;
        chk("lock_c1_req", sbr_req, 1'b1);
        chk("lock_c1_addr", sbr_addr, A1);
        chk("lock_c1_gnt", mgr_gnt, 2'b00);
        tick();
        for (int c = 2; c <= 3; c++) begin
            drive(2'b11, 1'b0, 1'b0);
            #3;
            chk($sformatf("lock_c%0d_addr", c), sbr_addr, A1);
            chk($sformatf("lock_c%0d_gnt", c), mgr_gnt, 2'b00);
            tick();
        end
        drive(2'b11, 1'b1, 1'b0);
        #3;
        chk("lock_c4_gnt", mgr_gnt, 2'b10);
        chk("lock_c4_addr", sbr_addr, A1);
        tick();
        drive(2'b01, 1'b1, 1'b0);
        #3;
        chk("lock_c5_gnt", mgr_gnt, 2'b01);
        chk("lock_c5_addr", sbr_addr, A0);
        tick();
        drive(2'b00, 1'b0, 1'b1);
        #3;
        chk("lock_rsp1", mgr_rvalid, 2'b10);
        tick();
        drive(2'b00, 1'b0, 1'b1);
        #3;
        chk("lock_rsp2", mgr_rvalid, 2'b01);
        tick();

        // Reset with two outstanding, pointer left at 1.
        drive(2'b01, 1'b1, 1'b0);
        #3;
        chk("mid_g1", mgr_gnt, 2'b01);
        tick();
        drive(2'b01, 1'b1, 1'b0);
        #3;
        chk("mid_g2", mgr_gnt, 2'b01);
        tick();
        idle_inputs();
        rst = 1'b1;
        #3;
        chk("mid_rst_spur", spurious, 1'b0);
        chk("mid_rst_req", sbr_req, 1'b0);
        tick();
        rst = 1'b0;
        drive(2'b00, 1'b0, 1'b1);
        #3;
        chk("mid_spur", spurious, 1'b1);
        chk("mid_rvalid", mgr_rvalid, 2'b00);
        tick();
        drive(2'b11, 1'b1, 1'b0);
        #3;
        chk("mid_m0_first", mgr_gnt, 2'b01);
        tick();
        drive(2'b11, 1'b1, 1'b0);
        #3;
        chk("mid_m1_next", mgr_gnt, 2'b10);
        tick();

        // Random traffic against the queue model.
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            mgr_req = 2'($urandom);
            if (locked) mgr_req[lidx] = 1'b1;
            for (int i = 0; i < N; i++) begin
                mgr_addr[i]  = $urandom;
                mgr_wdata[i] = $urandom;
                mgr_we[i]    = 1'($urandom);
                mgr_be[i]    = 4'($urandom);
            end
            sbr_gnt    = ($urandom_range(0, 9) < 6);
            sbr_rvalid = (q.size() > 0) ? ($urandom_range(0, 9) < 5)
                                        : ($urandom_range(0, 19) == 0);
            sbr_rdata  = $urandom;
            sbr_err    = 1'($urandom);
            #3;
            model_check();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
